// File: rtl/pio_pkg.sv
// pio_pkg: shared types and constants for the PIO clock-divider control path.
//   clkdiv_state_t : per-state-machine divider sequencing state
//   clkdiv_div_t   : 16.8 fixed-point divisor layout
//   div_illegal()  : true for a divisor with zero integer and non-zero fraction
package pio_pkg;

  localparam int unsigned DIV_INT_W  = 16;
  localparam int unsigned DIV_FRAC_W = 8;
  localparam int unsigned DIV_W      = DIV_INT_W + DIV_FRAC_W;
  localparam int unsigned SM_IDX_W   = 2;
  localparam logic [DIV_W-1:0] DIV_RESET = 24'h000100;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2,
    RST  = 2'd3
  } clkdiv_state_t;

  typedef struct packed {
    logic [DIV_INT_W-1:0]  int_part;
    logic [DIV_FRAC_W-1:0] frac;
  } clkdiv_div_t;

  // Integer part 0 means /65536 only when the fraction is also 0.
  function automatic logic div_illegal(input clkdiv_div_t d);
    return (d.int_part == '0) && (d.frac != '0);
  endfunction

endpackage

// File: rtl/pio_clkdiv_slot.sv
// pio_clkdiv_slot: divisor sequencing for one state machine.
//   cfg_we/cfg_div        legal divisor write targeted at this slot
//   ctrl_we/enable/restart control strobe and this slot's ctrl bits
//   penable_in            penable from this slot's divider
//   div                   active divisor to the divider
//   div_reset             divider synchronous reset (OFF or RST)
//   penable               gated penable to the state machine (combinational)
//   enabled, pending      state decodes (RUN/PEND/RST, PEND)
module pio_clkdiv_slot
  import pio_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             ctrl_we,
  input  logic             enable,
  input  logic             restart,
  input  logic             penable_in,
  output logic [DIV_W-1:0] div,
  output logic             div_reset,
  output logic             penable,
  output logic             enabled,
  output logic             pending
);

  clkdiv_state_t    state, state_n;
  logic [DIV_W-1:0] active, active_n;
  logic [DIV_W-1:0] shadow, shadow_n;
  logic             dis_req, rst_req;

  assign dis_req = ctrl_we && !enable;
  assign rst_req = ctrl_we && enable && restart;

  // State and divisor registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= OFF;
      active <= DIV_RESET;
      shadow <= DIV_RESET;
    end else begin
      state  <= state_n;
      active <= active_n;
      shadow <= shadow_n;
    end
  end

  // Next state and divisor selection; disable beats restart beats cfg
  always_comb begin
    state_n  = state;
    active_n = active;
    shadow_n = shadow;
    case (state)
      OFF: begin
        if (cfg_we) begin
          active_n = cfg_div;
          shadow_n = cfg_div;
        end
        if (ctrl_we && enable) state_n = RUN;
      end
      RUN, PEND: begin
        if (dis_req || rst_req) begin
          state_n = dis_req ? OFF : RST;
          // A coincident write is newest; otherwise flush any pending shadow.
          if (cfg_we)              active_n = cfg_div;
          else if (state == PEND)  active_n = shadow;
          shadow_n = active_n;
        end else if (cfg_we) begin
          // Held in PEND even if penable coincides; applies on the next one.
          shadow_n = cfg_div;
          state_n  = PEND;
        end else if (state == PEND && penable_in) begin
          active_n = shadow;
          state_n  = RUN;
        end
      end
      RST: begin
        if (cfg_we) begin
          active_n = cfg_div;
          shadow_n = cfg_div;
        end
        state_n = dis_req ? OFF : RUN;
      end
      default: state_n = OFF;
    endcase
  end

  assign div       = active;
  assign div_reset = (state == OFF) || (state == RST);
  assign penable   = penable_in && ((state == RUN) || (state == PEND));
  assign enabled   = (state != OFF);
  assign pending   = (state == PEND);

endmodule

// File: rtl/pio_clkdiv_ctrl.sv
// pio_clkdiv_ctrl: clock-divider configuration/sequencing for NUM_SM state machines.
//   cfg_we/cfg_sm/cfg_div        divisor write strobe, target SM, divisor
//   ctrl_we/ctrl_enable/ctrl_restart  control strobe with per-SM enable/restart
//   div_penable_in               penable from each divider instance
//   div_out                      active divisor per SM (SM i at [i*DIV_W +: DIV_W])
//   div_reset                    divider synchronous reset per SM
//   sm_penable                   gated penable per SM (zero latency)
//   sm_enabled, upd_pending      per-SM status
//   cfg_err                      1-cycle pulse after an illegal divisor write
module pio_clkdiv_ctrl
  import pio_pkg::*;
#(
  parameter int unsigned NUM_SM = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cfg_we,
  input  logic [SM_IDX_W-1:0]     cfg_sm,
  input  logic [DIV_W-1:0]        cfg_div,
  input  logic                    ctrl_we,
  input  logic [NUM_SM-1:0]       ctrl_enable,
  input  logic [NUM_SM-1:0]       ctrl_restart,
  input  logic [NUM_SM-1:0]       div_penable_in,
  output logic [NUM_SM*DIV_W-1:0] div_out,
  output logic [NUM_SM-1:0]       div_reset,
  output logic [NUM_SM-1:0]       sm_penable,
  output logic [NUM_SM-1:0]       sm_enabled,
  output logic [NUM_SM-1:0]       upd_pending,
  output logic                    cfg_err
);

  logic              illegal;
  logic [NUM_SM-1:0] slot_we;
  logic [NUM_SM-1:0] slot_err;

  assign illegal = div_illegal(clkdiv_div_t'(cfg_div));

  // Index decode; an index with no slot matches nothing and is silently dropped.
  always_comb begin
    slot_we  = '0;
    slot_err = '0;
    for (int i = 0; i < int'(NUM_SM); i++) begin
      if (cfg_we && (cfg_sm == SM_IDX_W'(i))) begin
        slot_we[i]  = !illegal;
        slot_err[i] = illegal;
      end
    end
  end

  // Error pulse register
  always_ff @(posedge clk) begin
    if (reset) cfg_err <= 1'b0;
    else       cfg_err <= |slot_err;
  end

  for (genvar g = 0; g < int'(NUM_SM); g++) begin : g_slot
    pio_clkdiv_slot u_slot (
      .clk        (clk),
      .reset      (reset),
      .cfg_we     (slot_we[g]),
      .cfg_div    (cfg_div),
      .ctrl_we    (ctrl_we),
      .enable     (ctrl_enable[g]),
      .restart    (ctrl_restart[g]),
      .penable_in (div_penable_in[g]),
      .div        (div_out[g*DIV_W +: DIV_W]),
      .div_reset  (div_reset[g]),
      .penable    (sm_penable[g]),
      .enabled    (sm_enabled[g]),
      .pending    (upd_pending[g])
    );
  end

endmodule

// File: tb/tb_pio_clkdiv_ctrl.sv
// tb_pio_clkdiv_ctrl: directed test of pio_clkdiv_ctrl with an integer-divider model
// feeding div_penable_in (penable on the first cycle out of reset, then every N cycles).
module tb_pio_clkdiv_ctrl;
  import pio_pkg::*;

  localparam int unsigned N = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 cfg_we;
  logic [SM_IDX_W-1:0]  cfg_sm;
  logic [DIV_W-1:0]     cfg_div;
  logic                 ctrl_we;
  logic [N-1:0]         ctrl_enable;
  logic [N-1:0]         ctrl_restart;
  logic [N-1:0]         div_penable_in;
  logic [N*DIV_W-1:0]   div_out;
  logic [N-1:0]         div_reset;
  logic [N-1:0]         sm_penable;
  logic [N-1:0]         sm_enabled;
  logic [N-1:0]         upd_pending;
  logic                 cfg_err;

  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  pio_clkdiv_ctrl #(.NUM_SM(N)) dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_we         (cfg_we),
    .cfg_sm         (cfg_sm),
    .cfg_div        (cfg_div),
    .ctrl_we        (ctrl_we),
    .ctrl_enable    (ctrl_enable),
    .ctrl_restart   (ctrl_restart),
    .div_penable_in (div_penable_in),
    .div_out        (div_out),
    .div_reset      (div_reset),
    .sm_penable     (sm_penable),
    .sm_enabled     (sm_enabled),
    .upd_pending    (upd_pending),
    .cfg_err        (cfg_err)
  );

  // Divider model (integer part only)
  logic [16:0] cnt [N];

  function automatic logic [16:0] period_of(input int i);
    logic [DIV_INT_W-1:0] ip;
    ip = div_out[i*DIV_W + DIV_FRAC_W +: DIV_INT_W];
    return (ip == '0) ? 17'h10000 : {1'b0, ip};
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < int'(N); i++) begin
      if (div_reset[i] !== 1'b0)                 cnt[i] <= '0;
      else if (cnt[i] + 17'd1 >= period_of(i))   cnt[i] <= '0;
      else                                       cnt[i] <= cnt[i] + 17'd1;
    end
  end

  always_comb begin
    for (int i = 0; i < int'(N); i++)
      div_penable_in[i] = (div_reset[i] === 1'b0) && (cnt[i] == '0);
  end

  function automatic logic [DIV_W-1:0] dv(input int i);
    return div_out[i*DIV_W +: DIV_W];
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cfg_we       = 1'b0;
    cfg_sm       = '0;
    cfg_div      = '0;
    ctrl_we      = 1'b0;
    ctrl_enable  = '0;
    ctrl_restart = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input int sm, input logic [DIV_W-1:0] d);
    cfg_we  = 1'b1;
    cfg_sm  = SM_IDX_W'(sm);
    cfg_div = d;
    cyc();
    idle();
  endtask

  task automatic ctrl(input logic [N-1:0] en, input logic [N-1:0] rs);
    ctrl_we      = 1'b1;
    ctrl_enable  = en;
    ctrl_restart = rs;
    cyc();
    idle();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_div_reset"}, 32'(div_reset), 32'hF);
    chk({tag, "_sm_penable"}, 32'(sm_penable), 32'h0);
    chk({tag, "_sm_enabled"}, 32'(sm_enabled), 32'h0);
    chk({tag, "_upd_pending"}, 32'(upd_pending), 32'h0);
    chk({tag, "_cfg_err"}, 32'(cfg_err), 32'h0);
    for (int i = 0; i < int'(N); i++)
      chk({tag, "_div_out"}, 32'(dv(i)), 32'h000100);
  endtask

  initial begin
    int w;
    idle();
    reset = 1'b1;
    repeat (3) cyc();
    chk_reset_vals("rst_held");
    reset = 1'b0;
    cyc();
    chk_reset_vals("rst_idle");

    // 1: enable SM0 at /3
    cfg(0, 24'h000300);
    chk("t1_div_off", 32'(dv(0)), 32'h000300);
    chk("t1_div_reset_off", 32'(div_reset[0]), 32'h1);
    ctrl(4'b0001, 4'b0000);
    chk("t1_div_reset_run", 32'(div_reset), 32'hE);
    chk("t1_enabled", 32'(sm_enabled), 32'h1);
    for (int k = 0; k < 6; k++) begin
      chk("t1_pen3", 32'(sm_penable[0]), (k % 3 == 0) ? 32'h1 : 32'h0);
      cyc();
    end

    // 2: /4 then write /2 mid-period
    ctrl(4'b0000, 4'b0000);
    chk("t2_off_div_reset", 32'(div_reset[0]), 32'h1);
    chk("t2_off_enabled", 32'(sm_enabled[0]), 32'h0);
    cfg(0, 24'h000400);
    ctrl(4'b0001, 4'b0000);                     // k=0
    chk("t2_k0_pen", 32'(sm_penable[0]), 32'h1);
    cyc();                                      // k=1
    cfg(0, 24'h000200);                         // k=2
    chk("t2_k2_pending", 32'(upd_pending[0]), 32'h1);
    chk("t2_k2_div", 32'(dv(0)), 32'h000400);
    chk("t2_k2_pen", 32'(sm_penable[0]), 32'h0);
    cyc();                                      // k=3
    chk("t2_k3_pen", 32'(sm_penable[0]), 32'h0);
    cyc();                                      // k=4
    chk("t2_k4_pen", 32'(sm_penable[0]), 32'h1);
    chk("t2_k4_div", 32'(dv(0)), 32'h000400);
    chk("t2_k4_pending", 32'(upd_pending[0]), 32'h1);
    cyc();                                      // k=5
    chk("t2_k5_div", 32'(dv(0)), 32'h000200);
    chk("t2_k5_pending", 32'(upd_pending[0]), 32'h0);
    chk("t2_k5_pen", 32'(sm_penable[0]), 32'h0);
    cyc();
    chk("t2_k6_pen", 32'(sm_penable[0]), 32'h1);
    cyc();
    chk("t2_k7_pen", 32'(sm_penable[0]), 32'h0);
    cyc();
    chk("t2_k8_pen", 32'(sm_penable[0]), 32'h1);

    // 3: SM0 /3, SM1 /5, synchronous restart
    ctrl(4'b0000, 4'b0000);
    cfg(0, 24'h000300);
    cfg(1, 24'h000500);
    ctrl(4'b0011, 4'b0000);                     // k=0
    chk("t3_k0_pen", 32'(sm_penable[1:0]), 32'h3);
    repeat (4) cyc();                           // k=4
    chk("t3_k4_pen", 32'(sm_penable[1:0]), 32'h0);
    ctrl(4'b0011, 4'b0011);                     // restart cycle
    chk("t3_rst_div_reset", 32'(div_reset[1:0]), 32'h3);
    chk("t3_rst_pen", 32'(sm_penable[1:0]), 32'h0);
    chk("t3_rst_enabled", 32'(sm_enabled[1:0]), 32'h3);
    cyc();                                      // new phase 0
    chk("t3_p0_pen", 32'(sm_penable[1:0]), 32'h3);
    chk("t3_p0_div_reset", 32'(div_reset[1:0]), 32'h0);
    cyc();
    chk("t3_p1_pen", 32'(sm_penable[1:0]), 32'h0);
    cyc(); cyc();
    chk("t3_p3_pen", 32'(sm_penable[1:0]), 32'h1);
    cyc(); cyc();
    chk("t3_p5_pen", 32'(sm_penable[1:0]), 32'h2);
    cyc();
    chk("t3_p6_pen", 32'(sm_penable[1:0]), 32'h1);

    // 4: illegal divisor rejected, divisor 0 accepted
    cfg(0, 24'h000080);
    chk("t4_err_pulse", 32'(cfg_err), 32'h1);
    chk("t4_err_div", 32'(dv(0)), 32'h000300);
    chk("t4_err_pending", 32'(upd_pending[0]), 32'h0);
    cyc();
    chk("t4_err_clear", 32'(cfg_err), 32'h0);
    cfg(0, 24'h000000);
    chk("t4_zero_no_err", 32'(cfg_err), 32'h0);
    chk("t4_zero_pending", 32'(upd_pending[0]), 32'h1);
    w = 0;
    while (upd_pending[0] === 1'b1 && w < 6) begin
      cyc();
      w++;
    end
    chk("t4_zero_applied", 32'(upd_pending[0]), 32'h0);
    chk("t4_zero_div", 32'(dv(0)), 32'h000000);

    // 5: disable SM0 while a shadow is pending
    cfg(0, 24'h000600);
    chk("t5_pending", 32'(upd_pending[0]), 32'h1);
    chk("t5_div_old", 32'(dv(0)), 32'h000000);
    ctrl(4'b0010, 4'b0000);
    chk("t5_off_div", 32'(dv(0)), 32'h000600);
    chk("t5_off_pen", 32'(sm_penable[0]), 32'h0);
    chk("t5_off_div_reset", 32'(div_reset[0]), 32'h1);
    chk("t5_off_pending", 32'(upd_pending[0]), 32'h0);
    chk("t5_enabled", 32'(sm_enabled), 32'h2);

    // 6: reset while SM2 has a pending update
    cfg(2, 24'h000400);
    ctrl(4'b0110, 4'b0000);
    cfg(2, 24'h000700);
    chk("t6_pending", 32'(upd_pending[2]), 32'h1);
    reset = 1'b1;
    cyc();
    chk_reset_vals("t6_rst");
    reset = 1'b0;
    cyc();
    chk("t6_after_pending", 32'(upd_pending), 32'h0);
    chk("t6_after_div2", 32'(dv(2)), 32'h000100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
